// File: rtl/avalon_mm_block_copier_pkg.sv
// Shared types and constants for the Avalon-MM block copier.
// Imported by the interface users and the copier core.
package avalon_copy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } state_t;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;
    localparam int         WORD_BYTES = 4;

    function automatic logic is_active(input state_t s);
        return (s == RD_REQ) || (s == RD_WAIT) || (s == WR_REQ);
    endfunction

endpackage

// File: rtl/avalon_mm_block_copier_if.sv
// Avalon-MM single-port memory bus with fixed-latency reads.
// The copier is the master; the data memory is the slave.
interface avalon_mm_block_copier_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [3:0]        byteenable;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avalon_mm_block_copier.sv
// Non-pipelined word copier: one read, then one write, per word.
// All bus outputs come straight from registers.
module avalon_mm_block_copier
    import avalon_copy_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int LEN_W  = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    avalon_mm_block_copier_if.master avm
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [ADDR_W-1:0] r_src, w_src;
    logic [ADDR_W-1:0] r_dst, w_dst;
    logic [LEN_W-1:0]  r_cnt, w_cnt;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic              r_read, w_read;
    logic              r_write, w_write;
    logic              r_busy, r_done;
    logic [ADDR_W-1:0] w_src_al, w_dst_al;
    logic              w_unused_lsbs;

    // Word alignment: the two byte-offset bits of the inputs are dropped.
    assign w_src_al      = {src_addr[ADDR_W-1:2], 2'b00};
    assign w_dst_al      = {dst_addr[ADDR_W-1:2], 2'b00};
    assign w_unused_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_src   = r_src;
        w_dst   = r_dst;
        w_cnt   = r_cnt;
        w_wdata = r_wdata;
        w_read  = 1'b0;
        w_write = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_src = w_src_al;
                    w_dst = w_dst_al;
                    w_cnt = length;
                    if (length == '0) begin
                        w_state = DONE;
                    end else begin
                        w_state = RD_REQ;
                        w_read  = 1'b1;
                        w_addr  = w_src_al;
                    end
                end
            end
            RD_REQ: begin
                if (avm.waitrequest) w_read = 1'b1;
                else                 w_state = RD_WAIT;
            end
            RD_WAIT: begin
                if (avm.readdatavalid) begin
                    w_state = WR_REQ;
                    w_write = 1'b1;
                    w_addr  = r_dst;
                    w_wdata = avm.readdata;
                end
            end
            WR_REQ: begin
                if (avm.waitrequest) begin
                    w_write = 1'b1;
                end else begin
                    w_src = r_src + STEP;
                    w_dst = r_dst + STEP;
                    w_cnt = r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) begin
                        w_state = DONE;
                    end else begin
                        w_state = RD_REQ;
                        w_read  = 1'b1;
                        w_addr  = r_src + STEP;
                    end
                end
            end
            DONE:    w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_wdata <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_src   <= w_src;
            r_dst   <= w_dst;
            r_cnt   <= w_cnt;
            r_wdata <= w_wdata;
            r_read  <= w_read;
            r_write <= w_write;
            r_busy  <= is_active(w_state);
            r_done  <= (w_state == DONE);
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign avm.address    = r_addr;
    assign avm.read       = r_read;
    assign avm.write      = r_write;
    assign avm.writedata  = r_wdata;
    assign avm.byteenable = BYTEEN_ALL;

endmodule

// File: tb/tb_avalon_mm_block_copier.sv
// Randomized bench for the block copier against a word-level copy model
// and a fixed-latency memory slave with programmable wait states.
module tb_avalon_mm_block_copier;

    localparam int ADDR_W = 15;
    localparam int LEN_W  = 14;
    localparam int WORDS  = 8192;

    typedef logic [ADDR_W+31:0] wr_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;

    avalon_mm_block_copier_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

    avalon_mm_block_copier #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W),
        .DATA_W(32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .length  (length),
        .busy    (busy),
        .done    (done),
        .avm     (bus)
    );

    always #5 clk = ~clk;

    logic [31:0]       mem     [WORDS];
    logic [31:0]       ref_mem [WORDS];
    logic [ADDR_W-1:0] rd_q[$];
    wr_t               wr_q[$];
    int                wait_cfg  = 0;
    int                stall_cnt = 0;
    int                n_checks  = 0;
    int                n_fail    = 0;

    // Each new request is stalled for wait_cfg cycles before acceptance.
    assign bus.waitrequest = (bus.read || bus.write) && (stall_cnt < wait_cfg);

    always @(posedge clk) begin
        bus.readdatavalid <= 1'b0;
        if (bus.read && !bus.waitrequest) begin
            bus.readdatavalid <= 1'b1;
            bus.readdata      <= mem[bus.address[ADDR_W-1:2]];
            rd_q.push_back(bus.address);
        end
        if (bus.write && !bus.waitrequest) begin
            mem[bus.address[ADDR_W-1:2]] <= bus.writedata;
            wr_q.push_back({bus.address, bus.writedata});
        end
        if ((bus.read || bus.write) && bus.waitrequest)
            stall_cnt <= stall_cnt + 1;
        else
            stall_cnt <= 0;
    end

    task automatic set_word(input int idx, input logic [31:0] v);
        mem[idx] <= v;
        ref_mem[idx] = v;
    endtask

    task automatic run_copy(input logic [ADDR_W-1:0] src,
                            input logic [ADDR_W-1:0] dst,
                            input int len, input int w,
                            input bit repulse, input bit bogus_after,
                            input string tag);
        logic [ADDR_W-1:0] s, d, ra, wa;
        logic [ADDR_W-1:0] exp_rd[$];
        wr_t               exp_wr[$];
        logic [ADDR_W-1:0] p_addr;
        logic [31:0]       p_wd;
        logic              p_rd, p_wr, p_hold;
        int exp_done, done_k, busy_bad, bus_bad, stab_bad, bad, first;
        s = {src[ADDR_W-1:2], 2'b00};
        d = {dst[ADDR_W-1:2], 2'b00};
        for (int i = 0; i < len; i++) begin
            ra = s + ADDR_W'(4 * i);
            wa = d + ADDR_W'(4 * i);
            exp_rd.push_back(ra);
            ref_mem[wa[ADDR_W-1:2]] = ref_mem[ra[ADDR_W-1:2]];
            exp_wr.push_back({wa, ref_mem[wa[ADDR_W-1:2]]});
        end
        exp_done = (len == 0) ? 1 : 1 + len * (3 + 2 * w);
        wait_cfg = w;
        rd_q.delete();
        wr_q.delete();
        src_addr = src;
        dst_addr = dst;
        length   = LEN_W'(len);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_addr = ADDR_W'($urandom);
        dst_addr = ADDR_W'($urandom);
        length   = LEN_W'($urandom);
        done_k = 0; busy_bad = 0; bus_bad = 0; stab_bad = 0;
        p_hold = 1'b0; p_addr = '0; p_wd = '0; p_rd = 1'b0; p_wr = 1'b0;
        for (int k = 1; k <= exp_done + 10 && done_k == 0; k++) begin
            @(negedge clk);
            if (bus.read && bus.write) bus_bad++;
            if ((bus.read || bus.write) &&
                (bus.byteenable !== 4'hF || bus.address[1:0] !== 2'b00))
                bus_bad++;
            if (len == 0 && (bus.read || bus.write)) bus_bad++;
            if (p_hold && (bus.address !== p_addr || bus.read !== p_rd ||
                bus.write !== p_wr || (p_wr && bus.writedata !== p_wd)))
                stab_bad++;
            p_hold = (bus.read || bus.write) && bus.waitrequest;
            p_addr = bus.address;
            p_rd   = bus.read;
            p_wr   = bus.write;
            p_wd   = bus.writedata;
            if (done === 1'b1) begin
                done_k = k;
                if (busy !== 1'b0) busy_bad++;
                if (bogus_after) begin
                    start    = 1'b1;
                    src_addr = ADDR_W'($urandom);
                    length   = LEN_W'(7);
                end
            end else if (busy !== (len != 0)) begin
                busy_bad++;
            end
            if (repulse && k == 3) begin
                start    = 1'b1;
                src_addr = ADDR_W'($urandom);
                dst_addr = ADDR_W'($urandom);
                length   = LEN_W'(1);
            end
            if (repulse && k == 4) start = 1'b0;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (done_k !== exp_done) begin
            n_fail++;
            $display("FAIL %s done_cycle: got T+%0d expected T+%0d",
                     tag, done_k, exp_done);
        end
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || bus.read !== 1'b0 ||
            bus.write !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: done=%b busy=%b rd=%b wr=%b expected 0",
                     tag, done, busy, bus.read, bus.write);
        end
        n_checks++;
        if (busy_bad !== 0) begin
            n_fail++;
            $display("FAIL %s busy: %0d bad cycles expected 0", tag, busy_bad);
        end
        n_checks++;
        if (bus_bad !== 0) begin
            n_fail++;
            $display("FAIL %s bus: %0d bad cycles expected 0", tag, bus_bad);
        end
        n_checks++;
        if (stab_bad !== 0) begin
            n_fail++;
            $display("FAIL %s stall_stable: %0d bad cycles expected 0",
                     tag, stab_bad);
        end
        bad = (rd_q.size() != exp_rd.size()) ? 1 : 0;
        first = -1;
        for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
            if (rd_q[i] !== exp_rd[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL %s reads: got %0d reads expected %0d, first bad idx %0d",
                     tag, rd_q.size(), exp_rd.size(), first);
        end
        bad = (wr_q.size() != exp_wr.size()) ? 1 : 0;
        first = -1;
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
            if (wr_q[i] !== exp_wr[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            if (first >= 0)
                $display("FAIL %s writes: idx %0d got %h expected %h",
                         tag, first, wr_q[first], exp_wr[first]);
            else
                $display("FAIL %s writes: got %0d writes expected %0d",
                         tag, wr_q.size(), exp_wr.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.read !== 1'b0 ||
            bus.write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b rd=%b wr=%b expected 0",
                     busy, done, bus.read, bus.write);
        end
        n_checks++;
        if (bus.address !== '0 || bus.writedata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: addr=%h wdata=%h expected 0",
                     bus.address, bus.writedata);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++)
            set_word(32'h40 + i, 32'h11111111 * (i + 1));
        run_copy(15'h0100, 15'h0800, 4, 0, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_zero_length();
        run_copy(15'h0200, 15'h0300, 0, 0, 1'b0, 1'b0, "zero_len");
    endtask

    task automatic test_waitrequest();
        run_copy(15'h1001, 15'h1802, 2, 3, 1'b0, 1'b0, "wait3");
    endtask

    task automatic test_wrap();
        run_copy(15'h7FF8, 15'h0000, 3, 1, 1'b0, 1'b0, "wrap");
    endtask

    task automatic test_back_to_back();
        run_copy(15'h0500, 15'h0A00, 4, 0, 1'b1, 1'b1, "restart");
        run_copy(15'h0A00, 15'h0C00, 3, 1, 1'b0, 1'b0, "after_done");
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++)
            run_copy(ADDR_W'($urandom), ADDR_W'($urandom),
                     (n == 5) ? 0 : int'($urandom_range(1, 12)),
                     int'($urandom_range(0, 2)), 1'b0, 1'b0, "random");
    endtask

    task automatic test_reset_abort();
        logic [ADDR_W-1:0] s, d;
        int quiet_bad;
        s = 15'h2000;
        d = 15'h3000;
        // Only word 0 is expected to land before the abort.
        ref_mem[d[ADDR_W-1:2]] = ref_mem[s[ADDR_W-1:2]];
        wait_cfg = 3;
        rd_q.delete();
        wr_q.delete();
        src_addr = s;
        dst_addr = d;
        length   = LEN_W'(5);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++;
        if (bus.write !== 1'b1 || bus.address !== d + 15'd4) begin
            n_fail++;
            $display("FAIL abort_setup: wr=%b addr=%h expected 1 and %h",
                     bus.write, bus.address, d + 15'd4);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.read !== 1'b0 ||
            bus.write !== 1'b0 || bus.address !== '0 ||
            bus.writedata !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%b done=%b rd=%b wr=%b addr=%h wd=%h expected 0",
                     busy, done, bus.read, bus.write, bus.address, bus.writedata);
        end
        quiet_bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || bus.read !== 1'b0 ||
                bus.write !== 1'b0)
                quiet_bad++;
        end
        n_checks++;
        if (quiet_bad !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d active cycles expected 0", quiet_bad);
        end
        n_checks++;
        if (wr_q.size() != 1 ||
            wr_q[0] !== {d, ref_mem[d[ADDR_W-1:2]]}) begin
            n_fail++;
            $display("FAIL abort_writes: got %0d writes expected 1", wr_q.size());
        end
        n_checks++;
        if (mem[d[ADDR_W-1:2] + 1] !== ref_mem[d[ADDR_W-1:2] + 1]) begin
            n_fail++;
            $display("FAIL abort_mem: got %h expected %h",
                     mem[d[ADDR_W-1:2] + 1], ref_mem[d[ADDR_W-1:2] + 1]);
        end
    endtask

    task automatic test_full_length();
        run_copy(15'h4000, 15'h0000, WORDS, 0, 1'b0, 1'b0, "full");
    endtask

    initial begin
        logic [31:0] v;
        reset_n  = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        for (int i = 0; i < WORDS; i++) begin
            v = $urandom;
            set_word(i, v);
        end
        test_reset();
        test_basic();
        test_zero_length();
        test_waitrequest();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_full_length();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
